mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, instruction/data word width.
REQ-002 Parameter ADDR_W, default 8, memory address / immediate field width (ADDR_W <= OP_LSB).
REQ-003 Parameter OP_LSB, default 11, bit position of the 2-bit opcode field instr[OP_LSB+1:OP_LSB] (OP_LSB+1 <= DATA_W-1).
REQ-004 Parameter MEM_LAT, default 2, memory access cycles (>= 1).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 instr_valid  in  1  instruction offered.
REQ-008 instr  in  DATA_W  instruction word.
REQ-009 instr_ready  out  1  controller can accept an instruction.
REQ-010 abort  in  1  synchronous cancel of the operation in flight.
REQ-011 st_data  in  DATA_W  store data, sampled at acceptance.
REQ-012 mem_rdata  in  DATA_W  memory read data.
REQ-013 mem_addr  out  ADDR_W  memory address.
REQ-014 mem_wdata  out  DATA_W  memory write data.
REQ-015 mem_re / mem_we  out  1 each  memory read / write strobes.
REQ-016 wb_en  out  1  register writeback strobe; wb_data  out  DATA_W  writeback value.
REQ-017 done  out  1  one-cycle completion pulse; busy  out  1  state != IDLE.

Function
REQ-018 Opcodes SHALL be: 00 LDI (zero-extend instr[ADDR_W-1:0]), 01 LDIS (sign-extend instr[ADDR_W-1:0]), 10 LOAD, 11 STORE; address = instr[ADDR_W-1:0].
REQ-019 FSM states SHALL be IDLE, DECODE, MEM, DONE.
REQ-020 IDLE: instr_ready = !abort; on instr_valid && instr_ready the block SHALL latch instr and st_data and go to DECODE.
REQ-021 DECODE (1 cycle): LDI/LDIS -> DONE; LOAD/STORE -> MEM with counter loaded to MEM_LAT-1.
REQ-022 MEM: mem_re (LOAD) or mem_we (STORE) SHALL be high every MEM cycle with mem_addr/mem_wdata stable; counter decrements each cycle; exit to DONE when counter is 0.
REQ-023 LOAD SHALL capture mem_rdata on the clock edge leaving MEM.
REQ-024 DONE (1 cycle): done = 1; wb_en = 1 for LDI/LDIS/LOAD with wb_data = extended immediate or captured read data; wb_en = 0 for STORE; next state IDLE.
REQ-025 Latency from accepting edge: LDI/LDIS done in cycle 2; LOAD/STORE done in cycle 2+MEM_LAT; next instruction accepted in the cycle after DONE (no back-to-back acceptance in DONE).
REQ-026 abort in DECODE, MEM or DONE SHALL force IDLE on the next edge; aborted operation SHALL produce no done, no wb_en, and strobes SHALL drop at that edge; abort in DONE suppresses done/wb_en combinationally in that cycle.
REQ-027 abort high in IDLE SHALL block acceptance even if instr_valid is high.
REQ-028 mem_re, mem_we, wb_en, done SHALL be 0 in every state not listed above; mem_re and mem_we SHALL never be high together.
REQ-029 All outputs except instr_ready/done/wb_en gating by abort SHALL be register-driven.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counter 0, latched instr/data 0, all outputs 0 except instr_ready = 1 after release.
REQ-031 Reset mid-MEM SHALL drop mem_re/mem_we asynchronously; no done follows.

Structure
REQ-032 Package mem_pkg SHALL hold the opcode enum (OP_LDI, OP_LDIS, OP_LOAD, OP_STORE) and state enum.
REQ-033 Sub-module mem_op_decode SHALL extract opcode, address and extended immediate from instr (combinational, parametrised as above).
REQ-034 Counter width SHALL be $clog2(MEM_LAT+1).

Verification
REQ-035 LDI: instr=16'h00A5 accepted -> cycle 2 done=1, wb_en=1, wb_data=16'h00A5.
REQ-036 LDIS: instr=16'h0880 -> wb_data=16'hFF80 in cycle 2.
REQ-037 LOAD MEM_LAT=2: instr=16'h1012, mem_rdata=16'hBEEF -> mem_re high cycles 2-3, mem_addr=8'h12, cycle 4 wb_data=16'hBEEF, done=1.
REQ-038 STORE: instr=16'h1834, st_data=16'h1234 -> mem_we high cycles 2-3, mem_wdata=16'h1234, cycle 4 done=1, wb_en=0.
REQ-039 abort in first MEM cycle of LOAD -> mem_re low next cycle, busy=0, no done/wb_en; new LDI then completes normally.
REQ-040 rst_n low during STORE MEM -> mem_we 0 immediately; after release instr_ready=1, no done.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory access controller:
// opcode and FSM state encodings.
package mem_pkg;

   typedef enum logic [1:0] {
      OP_LDI   = 2'b00,
      OP_LDIS  = 2'b01,
      OP_LOAD  = 2'b10,
      OP_STORE = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_DECODE = 2'b01,
      S_MEM    = 2'b10,
      S_DONE   = 2'b11
   } state_t;

endpackage

// File: rtl/mem_op_decode.sv
// Field extraction for the controller: opcode,
// memory address and extended immediate.
module mem_op_decode
   import mem_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int OP_LSB = 11
) (
   input  logic [DATA_W-1:0] instr,
   output op_t               op,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] imm
);

   logic unused_bits;

   assign unused_bits = ^instr;
   assign op   = op_t'(instr[OP_LSB+1:OP_LSB]);
   assign addr = instr[ADDR_W-1:0];

   always_comb begin
      imm = {{(DATA_W-ADDR_W){1'b0}}, addr};
      if (op == OP_LDIS)
         imm = {{(DATA_W-ADDR_W){addr[ADDR_W-1]}}, addr};
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store/immediate controller with
// fixed-latency memory strobes and abort support.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 8,
   parameter int OP_LSB  = 11,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instr,
   output logic              instr_ready,
   input  logic              abort,
   input  logic [DATA_W-1:0] st_data,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   output logic              wb_en,
   output logic [DATA_W-1:0] wb_data,
   output logic              done,
   output logic              busy
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   instr_q;
   logic [DATA_W-1:0]   st_q;
   logic                done_r;
   logic                wb_r;

   op_t                 dec_op;
   logic [ADDR_W-1:0]   dec_addr;
   logic [DATA_W-1:0]   dec_imm;

   mem_op_decode #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .OP_LSB (OP_LSB)
   ) u_dec (
      .instr (instr_q),
      .op    (dec_op),
      .addr  (dec_addr),
      .imm   (dec_imm)
   );

   // abort cancels a pending completion in the same cycle
   assign instr_ready = (state == S_IDLE) && !abort;
   assign done        = done_r && !abort;
   assign wb_en       = wb_r && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         instr_q   <= '0;
         st_q      <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         wb_data   <= '0;
         done_r    <= 1'b0;
         wb_r      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         wb_r   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (instr_valid && !abort) begin
                  instr_q <= instr;
                  st_q    <= st_data;
                  state   <= S_DECODE;
                  busy    <= 1'b1;
               end
            end
            S_DECODE: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (dec_op == OP_LDI || dec_op == OP_LDIS) begin
                  state   <= S_DONE;
                  wb_data <= dec_imm;
                  done_r  <= 1'b1;
                  wb_r    <= 1'b1;
               end else begin
                  state     <= S_MEM;
                  cnt       <= CNT_W'(MEM_LAT - 1);
                  mem_addr  <= dec_addr;
                  mem_wdata <= st_q;
                  mem_re    <= (dec_op == OP_LOAD);
                  mem_we    <= (dec_op == OP_STORE);
               end
            end
            S_MEM: begin
               if (abort) begin
                  state  <= S_IDLE;
                  busy   <= 1'b0;
                  mem_re <= 1'b0;
                  mem_we <= 1'b0;
                  cnt    <= '0;
               end else if (cnt == '0) begin
                  state  <= S_DONE;
                  mem_re <= 1'b0;
                  mem_we <= 1'b0;
                  done_r <= 1'b1;
                  wb_r   <= (dec_op == OP_LOAD);
                  if (dec_op == OP_LOAD)
                     wb_data <= mem_rdata;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized bench for mem_access_ctrl
// against a cycle-timeline reference model.
module tb_mem_access_ctrl;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic        abort;
   logic [15:0] st_data;
   logic [15:0] mem_rdata;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic        wb_en;
   logic [15:0] wb_data;
   logic        done;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mem_access_ctrl #(
      .DATA_W  (16),
      .ADDR_W  (8),
      .OP_LSB  (11),
      .MEM_LAT (LAT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .abort       (abort),
      .st_data     (st_data),
      .mem_rdata   (mem_rdata),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_re      (mem_re),
      .mem_we      (mem_we),
      .wb_en       (wb_en),
      .wb_data     (wb_data),
      .done        (done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: the op's visible timeline relative to the accepting edge.
   task automatic do_op(input logic [15:0] ins, input logic [15:0] sd,
                        input int ab);
      int op, dc;
      logic ld, sto, fin;
      logic [15:0] imm, exp_wb, rd, cap;
      op  = int'(ins[12:11]);
      ld  = (op == 2);
      sto = (op == 3);
      dc  = (op < 2) ? 2 : 2 + LAT;
      imm = {8'h00, ins[7:0]};
      exp_wb = (op == 1 && imm >= 16'd128) ? imm + 16'hFF00 : imm;
      cap = 16'h0;
      instr = ins;
      st_data = sd;
      instr_valid = 1'b1;
      abort = 1'b0;
      @(negedge clk);
      check("ready_idle", {15'b0, instr_ready}, 16'd1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr = 16'($urandom);
      st_data = 16'($urandom);
      for (int k = 1; k <= dc; k++) begin
         rd = 16'($urandom);
         mem_rdata = rd;
         abort = (k == ab);
         if (k == 1 + LAT) cap = rd;
         fin = (k == dc) && (k != ab);
         @(negedge clk);
         check("busy", {15'b0, busy}, 16'd1);
         check("ready_busy", {15'b0, instr_ready}, 16'd0);
         check("done", {15'b0, done}, {15'b0, fin});
         check("wb_en", {15'b0, wb_en}, {15'b0, fin && !sto});
         check("mem_re", {15'b0, mem_re},
               {15'b0, ld && k >= 2 && k <= 1 + LAT});
         check("mem_we", {15'b0, mem_we},
               {15'b0, sto && k >= 2 && k <= 1 + LAT});
         if ((ld || sto) && k >= 2 && k <= 1 + LAT)
            check("mem_addr", {8'h00, mem_addr}, imm);
         if (sto && k >= 2 && k <= 1 + LAT)
            check("mem_wdata", mem_wdata, sd);
         if (fin && !sto)
            check("wb_data", wb_data, ld ? cap : exp_wb);
         @(posedge clk); #1;
         if (k == ab) break;
      end
      abort = 1'b0;
      @(negedge clk);
      check("busy_after", {15'b0, busy}, 16'd0);
      check("ready_after", {15'b0, instr_ready}, 16'd1);
      check("done_after", {15'b0, done}, 16'd0);
      check("strobe_after", {14'b0, mem_re, mem_we}, 16'd0);
      check("wb_after", {15'b0, wb_en}, 16'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int ab, dc;
      logic [15:0] ri;
      rst_n = 1'b0;
      instr_valid = 1'b0;
      instr = 16'h0;
      abort = 1'b0;
      st_data = 16'h0;
      mem_rdata = 16'h0;
      #1;
      check("rst_done", {15'b0, done}, 16'd0);
      check("rst_busy", {15'b0, busy}, 16'd0);
      check("rst_strobes", {13'b0, mem_re, mem_we, wb_en}, 16'd0);
      check("rst_wb_data", wb_data, 16'h0);
      check("rst_addr", {8'h00, mem_addr}, 16'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", {15'b0, instr_ready}, 16'd1);
      @(posedge clk); #1;

      do_op(16'h00A5, 16'h0000, 0);
      do_op(16'h0880, 16'h0000, 0);
      do_op(16'h1012, 16'h0000, 0);
      do_op(16'h1834, 16'h1234, 0);
      do_op(16'h1012, 16'h0000, 2);
      do_op(16'h00A5, 16'h0000, 0);
      do_op(16'h0880, 16'h0000, 2);
      do_op(16'h1834, 16'h5555, 1);
      do_op(16'h1834, 16'hAAAA, 4);

      // abort in IDLE blocks acceptance
      instr = 16'h00A5;
      instr_valid = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      check("idle_abort_ready", {15'b0, instr_ready}, 16'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_abort_busy", {15'b0, busy}, 16'd0);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      abort = 1'b0;

      // reset during STORE memory phase
      instr = 16'h1834;
      st_data = 16'h1234;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("pre_rst_we", {15'b0, mem_we}, 16'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_we", {15'b0, mem_we}, 16'd0);
      check("rst_mid_busy", {15'b0, busy}, 16'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rel_ready", {15'b0, instr_ready}, 16'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_no_done", {14'b0, done, wb_en}, 16'd0);
      end
      @(posedge clk); #1;

      for (int n = 0; n < 60; n++) begin
         ri = 16'($urandom);
         dc = (ri[12] == 1'b0) ? 2 : 2 + LAT;
         ab = ($urandom_range(3) == 0) ? int'($urandom_range(dc, 1)) : 0;
         do_op(ri, 16'($urandom), ab);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
